// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side master for a single-port block RAM. A transfer is requested with a
//   base address and a word count. The block reads the RAM in address order and
//   presents each word on a valid/ready stream. The RAM returns data one cycle
//   after the read strobe. A 2-entry output FIFO absorbs that delay, so
//   back-pressure never loses data.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   cfg_start         1-cycle transfer request, ignored while busy
//   cfg_base_addr     first word address, sampled with cfg_start
//   cfg_count         word count 0..2**RAM_ADDR_BITS, sampled with cfg_start
//   busy              transfer in progress
//   done              1-cycle completion pulse
//   ram_read_enable   RAM read strobe
//   ram_address       RAM read address
//   ram_read_data     RAM read data, valid the cycle after ram_read_enable
//   m_valid, m_ready  stream handshake
//   m_data, m_last    stream payload and end-of-transfer marker
module bram_stream_reader #(
   parameter int unsigned RAM_WIDTH     = 8,
   parameter int unsigned RAM_ADDR_BITS = 13
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_start,
   input  logic [RAM_ADDR_BITS-1:0] cfg_base_addr,
   input  logic [RAM_ADDR_BITS:0]   cfg_count,
   output logic                     busy,
   output logic                     done,
   output logic                     ram_read_enable,
   output logic [RAM_ADDR_BITS-1:0] ram_address,
   input  logic [RAM_WIDTH-1:0]     ram_read_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [RAM_WIDTH-1:0]     m_data,
   output logic                     m_last
);

   localparam int unsigned CntW = RAM_ADDR_BITS + 1;

   typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

   state_e                   state_q, state_d;
   logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
   // Reads still to issue, and beats still to hand over downstream.
   logic [CntW-1:0]          issue_left_q, issue_left_d;
   logic [CntW-1:0]          beat_left_q, beat_left_d;
   logic                     done_q, done_d;
   // Set the cycle after a read strobe: ram_read_data carries a word to capture.
   logic                     inflight_q;

   logic [RAM_WIDTH-1:0]     fifo_mem_q [2];
   logic                     rd_ptr_q, wr_ptr_q;
   logic [1:0]               fifo_cnt_q;

   logic                     push, pop, issue;
   logic [2:0]               occupancy, limit;

   assign push = inflight_q;
   assign pop  = m_valid & m_ready;

   // Issue only if the word can never overflow the FIFO. Count the words already
   // buffered or in flight, less any word leaving this cycle.
   always_comb begin
      occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
      limit     = 3'd2 + {2'b00, pop};
      issue     = (state_q == StRead) && (occupancy < limit);
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      beat_left_d  = beat_left_q;
      done_d       = 1'b0;

      if (issue) begin
         addr_d       = addr_q + 1'b1;  // wraps modulo RAM depth
         issue_left_d = issue_left_q - 1'b1;
      end
      if (pop) begin
         beat_left_d = beat_left_q - 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (cfg_start) begin
               if (cfg_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d      = StRead;
                  addr_d       = cfg_base_addr;
                  issue_left_d = cfg_count;
                  beat_left_d  = cfg_count;
               end
            end
         end
         StRead: begin
            if (issue && (issue_left_q == CntW'(1))) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && (beat_left_q == CntW'(1))) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         issue_left_q <= '0;
         beat_left_q  <= '0;
         done_q       <= 1'b0;
         inflight_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         beat_left_q  <= beat_left_d;
         done_q       <= done_d;
         inflight_q   <= issue;
      end
   end

   // Two-entry FIFO. The issue rule means a push never meets a full FIFO
   // unless a pop happens in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_mem_q[i] <= '0;
         end
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         fifo_cnt_q <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= ram_read_data;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         unique case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   assign busy            = (state_q != StIdle);
   assign done            = done_q;
   assign ram_read_enable = issue;
   assign ram_address     = addr_q;
   assign m_valid         = (fifo_cnt_q != 2'd0);
   assign m_data          = fifo_mem_q[rd_ptr_q];
   // Words leave in address order, so the head is the final word once one beat remains.
   assign m_last          = m_valid && (beat_left_q == CntW'(1));

endmodule
